// File: rtl/mac_seq.sv
// Dot-product sequencer: streams len operand pairs into an external accumulator and returns its value.
// Result valid 2 cycles after the last accepted beat; in_ready only in STREAM, res_data held until res_ready.
module mac_seq #(
   parameter int WIDTH = 32,
   parameter int LEN_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [LEN_W-1:0]   len,
   input  logic               abort,
   output logic               busy,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_a,
   input  logic [WIDTH-1:0]   in_b,
   output logic               mac_clr,
   output logic               mac_en,
   output logic [WIDTH-1:0]   mac_a,
   output logic [WIDTH-1:0]   mac_b,
   input  logic [2*WIDTH-1:0] mac_acc,
   output logic               res_valid,
   input  logic               res_ready,
   output logic [2*WIDTH-1:0] res_data
);

   typedef enum logic [2:0] {IDLE, CLEAR, STREAM, DRAIN, DONE} state_t;

   state_t             state, state_nxt;
   logic [LEN_W-1:0]   remaining, remaining_nxt;
   logic [2*WIDTH-1:0] res_reg;

   assign res_data = res_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         remaining <= '0;
         res_reg   <= '0;
      end else begin
         state     <= state_nxt;
         remaining <= remaining_nxt;
         // mac_acc already reflects the final beat by the DRAIN cycle
         if (state == DRAIN && !abort)
            res_reg <= mac_acc;
      end
   end

   always_comb begin
      state_nxt     = state;
      remaining_nxt = remaining;
      busy          = (state != IDLE);
      in_ready      = 1'b0;
      mac_clr       = 1'b0;
      mac_en        = 1'b0;
      mac_a         = '0;
      mac_b         = '0;
      res_valid     = 1'b0;

      case (state)
         IDLE: begin
            if (start) begin
               remaining_nxt = len;
               state_nxt     = CLEAR;
            end
         end
         CLEAR: begin
            mac_clr   = 1'b1;
            state_nxt = (remaining != '0) ? STREAM : DRAIN;
         end
         STREAM: begin
            in_ready = 1'b1;
            if (in_valid) begin
               mac_en        = 1'b1;
               mac_a         = in_a;
               mac_b         = in_b;
               remaining_nxt = remaining - LEN_W'(1);
               if (remaining == LEN_W'(1))
                  state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            state_nxt = DONE;
         end
         DONE: begin
            res_valid = 1'b1;
            if (res_ready)
               state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase

      // abort wins over every other transition and suppresses all handshakes this cycle
      if (abort && state != IDLE) begin
         state_nxt     = IDLE;
         remaining_nxt = remaining;
         in_ready      = 1'b0;
         mac_en        = 1'b0;
         mac_a         = '0;
         mac_b         = '0;
         res_valid     = 1'b0;
      end
   end

endmodule

// File: tb/tb_mac_seq.sv
// Directed bench for mac_seq with a behavioural downstream accumulator.
module tb_mac_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] len;
   logic        abort;
   logic        busy;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_a, in_b;
   logic        mac_clr, mac_en;
   logic [31:0] mac_a, mac_b;
   logic [63:0] mac_acc;
   logic        res_valid;
   logic        res_ready;
   logic [63:0] res_data;

   int checks = 0;
   int failures = 0;

   logic [31:0] va [8];
   logic [31:0] vb [8];

   logic [63:0] r_data;
   int          r_busy, r_vld, r_beats, r_clr;
   bit          r_rdy_seen, r_unstable, r_mac_bad, r_abort_leak, r_timeout;

   always #5 clk = ~clk;

   mac_seq #(.WIDTH(32), .LEN_W(16)) dut (
      .clk(clk), .rst(rst), .start(start), .len(len), .abort(abort), .busy(busy),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
      .mac_clr(mac_clr), .mac_en(mac_en), .mac_a(mac_a), .mac_b(mac_b),
      .mac_acc(mac_acc), .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
   );

   // Downstream accumulator: registered, updates on the edge after mac_clr/mac_en
   always @(posedge clk) begin
      if (rst || mac_clr) mac_acc <= 64'd0;
      else if (mac_en)    mac_acc <= mac_acc + {32'd0, mac_a} * {32'd0, mac_b};
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      start = 0; len = 0; abort = 0; in_valid = 0; in_a = 0; in_b = 0; res_ready = 0;
   endtask

   // Runs one job and records what was observed; each test judges the record itself.
   task automatic run_job(input int n, input int gap, input int rdy_delay,
                          input int abort_after, input bit restart);
      int  i;
      bit  acc_now;
      r_data = 64'd0; r_busy = 0; r_vld = 0; r_beats = 0; r_clr = 0;
      r_rdy_seen = 0; r_unstable = 0; r_mac_bad = 0; r_abort_leak = 0; r_timeout = 0;
      start = 1; len = 16'(n);
      cyc();
      start = 0;
      for (i = 0; i < 200; i++) begin
         in_valid  = (r_beats < n) && (gap == 0 || i % 2 == 0);
         in_a      = va[r_beats % 8];
         in_b      = vb[r_beats % 8];
         res_ready = (r_vld >= rdy_delay);
         abort     = (abort_after >= 0 && r_beats == abort_after);
         start     = restart;
         len       = 16'd5;
         #1;
         if (!busy) break;
         r_busy++;
         if (res_valid) begin
            if (r_vld == 0) r_data = res_data;
            else if (res_data !== r_data) r_unstable = 1;
            r_vld++;
         end
         if (mac_clr) r_clr++;
         if (in_ready) r_rdy_seen = 1;
         acc_now = in_valid && in_ready;
         if (acc_now && !(mac_en && mac_a == in_a && mac_b == in_b)) r_mac_bad = 1;
         if (!acc_now && (mac_en || mac_a != 0 || mac_b != 0)) r_mac_bad = 1;
         if (abort && (in_ready || mac_en || res_valid)) r_abort_leak = 1;
         cyc();
         if (acc_now) r_beats++;
      end
      if (i == 200) r_timeout = 1;
      idle_inputs();
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1;
      start = 1; len = 16'd4; abort = 1; in_valid = 1;
      cyc(); cyc();
      idle_inputs();
      rst = 0;
      #1;
      checks++;
      if ({busy, in_ready, mac_clr, mac_en, res_valid} !== 5'b0) begin
         failures++; $display("FAIL reset_ctrl got %b want 00000", {busy, in_ready, mac_clr, mac_en, res_valid});
      end
      checks++;
      if (mac_a !== 32'd0 || mac_b !== 32'd0) begin
         failures++; $display("FAIL reset_operands got %h/%h want 0/0", mac_a, mac_b);
      end
      checks++;
      if (res_data !== 64'd0) begin
         failures++; $display("FAIL reset_res_data got %h want 0", res_data);
      end
      cyc();
   endtask

   task automatic test_back_to_back();
      va[0] = 2; vb[0] = 3; va[1] = 4; vb[1] = 5; va[2] = 6; vb[2] = 7;
      run_job(3, 0, 0, -1, 0);
      checks++;
      if (r_data !== 64'd68) begin failures++; $display("FAIL b2b_data got %0d want 68", r_data); end
      checks++;
      if (r_busy !== 6) begin failures++; $display("FAIL b2b_busy_cycles got %0d want 6", r_busy); end
      checks++;
      if (r_vld !== 1) begin failures++; $display("FAIL b2b_res_valid_cycles got %0d want 1", r_vld); end
      checks++;
      if (r_beats !== 3 || r_clr !== 1) begin
         failures++; $display("FAIL b2b_beats_clr got %0d/%0d want 3/1", r_beats, r_clr);
      end
      checks++;
      if (r_mac_bad || r_timeout) begin
         failures++; $display("FAIL b2b_mac_outputs got bad=%0d timeout=%0d want 0/0", r_mac_bad, r_timeout);
      end
      cyc();
      checks++;
      if (busy !== 1'b0 || res_valid !== 1'b0) begin
         failures++; $display("FAIL b2b_back_idle got busy=%b vld=%b want 0/0", busy, res_valid);
      end
   endtask

   task automatic test_overflow();
      va[0] = 32'hFFFFFFFF; vb[0] = 32'hFFFFFFFF; va[1] = 32'hFFFFFFFF; vb[1] = 32'hFFFFFFFF;
      run_job(2, 0, 0, -1, 0);
      checks++;
      if (r_data !== 64'hFFFFFFFC00000002) begin
         failures++; $display("FAIL overflow_data got %h want fffffffc00000002", r_data);
      end
      checks++;
      if (r_busy !== 5) begin failures++; $display("FAIL overflow_busy_cycles got %0d want 5", r_busy); end
   endtask

   task automatic test_stall();
      for (int k = 0; k < 4; k++) begin va[k] = 32'(k + 1); vb[k] = 32'(k + 1); end
      run_job(4, 1, 5, -1, 0);
      checks++;
      if (r_data !== 64'd30) begin failures++; $display("FAIL stall_data got %0d want 30", r_data); end
      checks++;
      if (r_vld !== 6) begin failures++; $display("FAIL stall_res_valid_cycles got %0d want 6", r_vld); end
      checks++;
      if (r_unstable || r_beats !== 4) begin
         failures++; $display("FAIL stall_hold got unstable=%0d beats=%0d want 0/4", r_unstable, r_beats);
      end
      checks++;
      if (r_mac_bad || r_timeout) begin
         failures++; $display("FAIL stall_mac_outputs got bad=%0d timeout=%0d want 0/0", r_mac_bad, r_timeout);
      end
   endtask

   task automatic test_len_zero();
      run_job(0, 0, 0, -1, 1);
      checks++;
      if (r_data !== 64'd0) begin failures++; $display("FAIL len0_data got %h want 0", r_data); end
      checks++;
      if (r_clr !== 1 || r_rdy_seen !== 1'b0) begin
         failures++; $display("FAIL len0_clr_ready got clr=%0d rdy=%0d want 1/0", r_clr, r_rdy_seen);
      end
      checks++;
      if (r_busy !== 3 || r_beats !== 0) begin
         failures++; $display("FAIL len0_busy_beats got %0d/%0d want 3/0", r_busy, r_beats);
      end
   endtask

   task automatic test_abort();
      for (int k = 0; k < 5; k++) begin va[k] = 32'(k + 2); vb[k] = 32'd9; end
      run_job(5, 0, 0, 2, 0);
      checks++;
      if (r_busy !== 4 || r_beats !== 2) begin
         failures++; $display("FAIL abort_busy_beats got %0d/%0d want 4/2", r_busy, r_beats);
      end
      checks++;
      if (r_vld !== 0 || r_abort_leak) begin
         failures++; $display("FAIL abort_no_result got vld=%0d leak=%0d want 0/0", r_vld, r_abort_leak);
      end
      va[0] = 3; vb[0] = 3;
      run_job(1, 0, 0, -1, 0);
      checks++;
      if (r_data !== 64'd9 || r_busy !== 4) begin
         failures++; $display("FAIL abort_next_job got data=%0d busy=%0d want 9/4", r_data, r_busy);
      end
   endtask

   task automatic test_abort_idle();
      abort = 1;
      cyc();
      checks++;
      if (busy !== 1'b0) begin failures++; $display("FAIL abort_idle_noop got busy=%b want 0", busy); end
      start = 1; len = 16'd1;
      cyc();
      start = 0; abort = 0;
      #1;
      checks++;
      if (busy !== 1'b1 || mac_clr !== 1'b1) begin
         failures++; $display("FAIL abort_start_together got busy=%b clr=%b want 1/1", busy, mac_clr);
      end
      abort = 1;
      cyc();
      abort = 0;
      #1;
      checks++;
      if (busy !== 1'b0) begin failures++; $display("FAIL abort_in_clear got busy=%b want 0", busy); end
   endtask

   task automatic test_reset_mid();
      start = 1; len = 16'd5;
      cyc();
      start = 0;
      in_valid = 1; in_a = 32'd1; in_b = 32'd1;
      cyc(); cyc(); cyc();
      #1;
      checks++;
      if (in_ready !== 1'b1) begin failures++; $display("FAIL rstmid_in_stream got in_ready=%b want 1", in_ready); end
      in_valid = 0; rst = 1; abort = 1; start = 1;
      cyc();
      rst = 0; abort = 0; start = 0; in_valid = 1;
      #1;
      checks++;
      if ({busy, in_ready, mac_clr, mac_en, res_valid} !== 5'b0 || mac_a !== 0 || mac_b !== 0) begin
         failures++; $display("FAIL rstmid_outputs got %b a=%h b=%h want 00000 0 0",
                              {busy, in_ready, mac_clr, mac_en, res_valid}, mac_a, mac_b);
      end
      checks++;
      if (res_data !== 64'd0) begin failures++; $display("FAIL rstmid_res_data got %h want 0", res_data); end
      in_valid = 0;
      cyc();
      va[0] = 7; vb[0] = 8;
      run_job(1, 0, 0, -1, 0);
      checks++;
      if (r_data !== 64'd56 || r_beats !== 1) begin
         failures++; $display("FAIL rstmid_next_job got data=%0d beats=%0d want 56/1", r_data, r_beats);
      end
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_overflow();
      test_stall();
      test_len_zero();
      test_abort();
      test_abort_idle();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mac_seq.md
MAC_SEQ -- requirements
Module: mac_seq

Interface
REQ-001 Parameter WIDTH, default 32, operand width; the accumulator width is 2*WIDTH.
REQ-002 Parameter LEN_W, default 16, width of the vector-length field.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 start  in  1  job request; sampled only in IDLE.
REQ-006 len  in  LEN_W  number of operand pairs in the job; sampled with start.
REQ-007 abort  in  1  cancels the job in progress.
REQ-008 busy  out  1  high whenever state != IDLE.
REQ-009 in_valid / in_ready  in / out  1 / 1  operand-stream handshake.
REQ-010 in_a, in_b  in  WIDTH  operand pair, qualified by in_valid.
REQ-011 mac_clr, mac_en  out  1  clear and accumulate-enable to the downstream accumulator.
REQ-012 mac_a, mac_b  out  WIDTH  operands to the accumulator.
REQ-013 mac_acc  in  2*WIDTH  registered accumulator value; it updates on the edge after mac_en or mac_clr.
REQ-014 res_valid / res_ready  out / in  1 / 1  result handshake.
REQ-015 res_data  out  2*WIDTH  dot-product result, stable while res_valid=1.

Function
REQ-016 The FSM SHALL have the states IDLE, CLEAR, STREAM, DRAIN and DONE.
REQ-017 IDLE: start=1 SHALL latch len into remaining and go to CLEAR; start=0 SHALL keep the FSM in IDLE.
REQ-018 CLEAR (1 cycle): mac_clr=1; next state is STREAM if remaining!=0, else DRAIN.
REQ-019 STREAM: in_ready=1; a beat SHALL be accepted on in_valid&in_ready.
- On an accepted beat: mac_en=1, mac_a=in_a, mac_b=in_b in the same cycle (combinational), and remaining decrements.
REQ-020 STREAM SHALL go to DRAIN on the beat accepted while remaining==1; in_valid=0 SHALL stall with no timeout.
REQ-021 DRAIN (1 cycle): res_data SHALL capture mac_acc at the end of the cycle; next state is DONE.
REQ-022 DONE: res_valid=1; on res_ready=1 the FSM SHALL go to IDLE; res_data SHALL hold until then.
REQ-023 Outside accepted beats, mac_en=0 and mac_a=mac_b=0; mac_clr SHALL be high only in CLEAR.
REQ-024 in_ready SHALL be 0 in every state other than STREAM.
REQ-025 Latency: the last beat accepted at edge k SHALL give res_valid=1 in the cycle after edge k+1.
- Minimum job of len=N: N+3 cycles from start to res_valid.
REQ-026 len=0: the result SHALL be 0 (CLEAR, DRAIN, DONE) and no beat SHALL be accepted.
REQ-027 start while busy SHALL be ignored and SHALL NOT alter the latched len.
REQ-028 abort=1 in any non-IDLE state SHALL force IDLE on the next edge.
- In that cycle, abort SHALL force in_ready=0, mac_en=0 and res_valid=0.
- abort overrides every other transition.
REQ-029 abort in IDLE SHALL have no effect; abort and start together in IDLE SHALL start the job.
REQ-030 res_ready=1 in the same cycle that DONE is entered SHALL complete the handshake in that one cycle.
REQ-031 No arithmetic is performed in this block; overflow of mac_acc wraps modulo 2^(2*WIDTH) and is passed through unchanged.

Reset
REQ-032 While rst=1 at an edge: state=IDLE, remaining=0, res_data=0.
- All outputs SHALL then be 0: busy, in_ready, mac_clr, mac_en, mac_a, mac_b, res_valid.
REQ-033 rst asserted mid-job SHALL discard the job with no pending beat or result; rst SHALL take priority over abort and start.

Verification
REQ-034 The bench SHALL use a reference accumulator model with the mac_acc timing of REQ-013 and cover the following directed scenarios.
REQ-035 len=3, beats (2,3),(4,5),(6,7) streamed back-to-back, res_ready=1 -> res_data=68; res_valid exactly 1 cycle; busy for 6 cycles.
REQ-036 len=2, beats (0xFFFFFFFF,0xFFFFFFFF)x2 -> res_data=0xFFFFFFFC00000002.
REQ-037 len=4, in_valid toggled every other cycle, res_ready held 0 for 5 cycles -> result 1*1+2*2+3*3+4*4=30; res_data stable throughout the stall.
REQ-038 len=0 -> mac_clr pulse, no in_ready, res_data=0.
- Second start during that job SHALL be ignored.
REQ-039 len=5, abort after 2 beats -> busy=0 next cycle; no res_valid.
- Following job len=1, beat (3,3) -> res_data=9.
REQ-040 rst asserted in STREAM with remaining=3 -> all outputs 0 the next cycle.
- Following job len=1, beat (7,8) -> res_data=56.
